// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: state encodings and
// datapath constants used by the control path.
package seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam logic [3:0] ALU_OP_NOP = 4'h0;

    // States that own the shared memory port and therefore hold a request.
    function automatic logic is_mem_phase(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Shared memory-port handshake between the sequencer (master) and the
// memory arbiter/controller (slave).
interface multicycle_sequencer_if;

    logic out_mem_req;
    logic out_mem_sel_data;
    logic out_mem_wr;
    logic in_mem_ack;

    modport master (
        output out_mem_req,
        output out_mem_sel_data,
        output out_mem_wr,
        input  in_mem_ack
    );

    modport slave (
        input  out_mem_req,
        input  out_mem_sel_data,
        input  out_mem_wr,
        output in_mem_ack
    );

endinterface

// File: rtl/multicycle_sequencer_wait_timer.sv
// Counts cycles spent waiting for a memory acknowledge; expires on the
// TIMEOUT-th waiting cycle.
module wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic in_clk,
    input  logic in_rst_n,
    input  logic in_clear,
    input  logic in_enable,
    output logic out_expired
);

    localparam int unsigned W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (in_clear) begin
            count_d = '0;
        end else if (in_enable) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_expired = (count_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB], sharing
// one memory port for fetch and data, with retire counting and timeout trap.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                       in_clk,
    input  logic                       in_rst_n,
    input  logic                       in_run,
    input  logic                       in_ctrl_memrd,
    input  logic                       in_ctrl_memwrt,
    input  logic                       in_ctrl_regwrt,
    input  logic                       in_ctrl_branch,
    input  logic                       in_ctrl_jump,
    input  logic                       in_br_taken,
    multicycle_sequencer_if.master     mem_if,
    output logic                       out_ir_load,
    output logic                       out_pc_inc,
    output logic                       out_pc_load,
    output logic                       out_reg_we,
    output logic                       out_busy,
    output logic                       out_err,
    output logic [CNT_W-1:0]           out_retired
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;

    logic   retire;
    logic   waiting;
    logic   expired;
    logic   mem_access;
    state_e boundary;

    assign waiting    = is_mem_phase(state_q);
    assign mem_access = in_ctrl_memrd | in_ctrl_memwrt;
    assign boundary   = in_run ? ST_FETCH : ST_IDLE;

    // An ack also restarts the count, so MEM -> FETCH back-to-back begins at 0.
    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .in_clk      (in_clk),
        .in_rst_n    (in_rst_n),
        .in_clear    (!waiting || mem_if.in_mem_ack),
        .in_enable   (waiting),
        .out_expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        out_ir_load = 1'b0;
        out_pc_inc  = 1'b0;
        out_pc_load = 1'b0;
        out_reg_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_if.in_mem_ack) begin
                    out_ir_load = 1'b1;
                    out_pc_inc  = 1'b1;
                    state_d     = ST_DECODE;
                end else if (expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (mem_access) begin
                    state_d = ST_MEM;
                end else if (in_ctrl_regwrt) begin
                    state_d = ST_WB;
                end else begin
                    out_pc_load = in_ctrl_jump | (in_ctrl_branch & in_br_taken);
                    retire      = 1'b1;
                    state_d     = boundary;
                end
            end
            ST_MEM: begin
                if (mem_if.in_mem_ack) begin
                    if (in_ctrl_jump) begin
                        out_pc_load = 1'b1;
                        retire      = 1'b1;
                        state_d     = boundary;
                    end else if (in_ctrl_regwrt) begin
                        state_d = ST_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = boundary;
                    end
                end else if (expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB: begin
                out_reg_we = 1'b1;
                retire     = 1'b1;
                state_d    = boundary;
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (retire) retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q   <= ST_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign mem_if.out_mem_req      = waiting;
    assign mem_if.out_mem_sel_data = (state_q == ST_MEM);
    assign mem_if.out_mem_wr       = (state_q == ST_MEM) && in_ctrl_memwrt;
    assign out_busy                = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign out_err                 = (state_q == ST_ERR);
    assign out_retired             = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Cycle-level scoreboard bench: each driven cycle pushes its expected outputs,
// a negedge monitor pops and compares them against the sequencer.
module tb_multicycle_sequencer;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TIMEOUT = 16;

    // flag vector: {memrd, memwrt, regwrt, branch, jump}
    localparam logic [4:0] F_NOP    = 5'b00000;
    localparam logic [4:0] F_ALU    = 5'b00100;
    localparam logic [4:0] F_LOAD   = 5'b10100;
    localparam logic [4:0] F_STORE  = 5'b01000;
    localparam logic [4:0] F_BR     = 5'b00010;
    localparam logic [4:0] F_JMP    = 5'b00001;
    localparam logic [4:0] F_LDJMP  = 5'b10101;

    logic clk;
    logic rst_n;
    logic run;
    logic memrd, memwrt, regwrt, branch, jump, br_taken;
    logic ir_load, pc_inc, pc_load, reg_we, busy, err;
    logic [CNT_W-1:0] retired;

    multicycle_sequencer_if mem_if ();

    multicycle_sequencer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .in_clk         (clk),
        .in_rst_n       (rst_n),
        .in_run         (run),
        .in_ctrl_memrd  (memrd),
        .in_ctrl_memwrt (memwrt),
        .in_ctrl_regwrt (regwrt),
        .in_ctrl_branch (branch),
        .in_ctrl_jump   (jump),
        .in_br_taken    (br_taken),
        .mem_if         (mem_if),
        .out_ir_load    (ir_load),
        .out_pc_inc     (pc_inc),
        .out_pc_load    (pc_load),
        .out_reg_we     (reg_we),
        .out_busy       (busy),
        .out_err        (err),
        .out_retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [8:0]       ctl;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t             exp_q[$];
    logic [CNT_W-1:0] exp_ret;
    int               n_cmp;
    int               n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ctl bit order: {req, sel_data, wr, ir_load, pc_inc, pc_load, reg_we, busy, err}
    function automatic logic [8:0] mk(input logic req, sel, wr, ir, pinc, pld, we, bsy, er);
        return {req, sel, wr, ir, pinc, pld, we, bsy, er};
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, "/ctl"},
                  {23'd0, mem_if.out_mem_req, mem_if.out_mem_sel_data, mem_if.out_mem_wr,
                   ir_load, pc_inc, pc_load, reg_we, busy, err},
                  {23'd0, e.ctl});
            check({e.tag, "/ret"}, {28'd0, retired}, {28'd0, e.ret});
        end
    end

    task automatic cyc(input string tag, input logic rst_v, input logic run_v, input logic ack_v,
                       input logic tk_v, input logic [4:0] f, input logic [8:0] ctl);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n              = rst_v;
        run                = run_v;
        mem_if.in_mem_ack  = ack_v;
        br_taken           = tk_v;
        {memrd, memwrt, regwrt, branch, jump} = f;
        if (!rst_v) exp_ret = '0;
        e.tag = tag;
        e.ctl = ctl;
        e.ret = exp_ret;
        exp_q.push_back(e);
    endtask

    // One complete instruction from FETCH to retire, expectations built from the
    // phase sequence each instruction class is supposed to follow.
    task automatic instr(input string tag, input logic [4:0] f, input logic tk, input int fwait,
                         input int mwait, input logic run_mid);
        logic is_mem, wr_f, rw_f, br_f, jp_f;
        is_mem = f[4] | f[3];
        wr_f   = f[3];
        rw_f   = f[2];
        br_f   = f[1];
        jp_f   = f[0];
        for (int i = 0; i < fwait; i++)
            cyc({tag, "/Fw"}, 1, 1, 0, tk, f, mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
        cyc({tag, "/F"}, 1, 1, 1, tk, f, mk(1, 0, 0, 1, 1, 0, 0, 1, 0));
        cyc({tag, "/D"}, 1, run_mid, 1, tk, f, mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        if (is_mem) begin
            cyc({tag, "/E"}, 1, run_mid, 1, tk, f, mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
            for (int i = 0; i < mwait; i++)
                cyc({tag, "/Mw"}, 1, run_mid, 0, tk, f, mk(1, 1, wr_f, 0, 0, 0, 0, 1, 0));
            cyc({tag, "/M"}, 1, run_mid, 1, tk, f, mk(1, 1, wr_f, 0, 0, jp_f, 0, 1, 0));
            if (!jp_f && rw_f)
                cyc({tag, "/W"}, 1, run_mid, 1, tk, f, mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
        end else if (rw_f) begin
            cyc({tag, "/E"}, 1, run_mid, 1, tk, f, mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
            cyc({tag, "/W"}, 1, run_mid, 1, tk, f, mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
        end else begin
            cyc({tag, "/E"}, 1, run_mid, 1, tk, f,
                mk(0, 0, 0, 0, 0, jp_f | (br_f & tk), 0, 1, 0));
        end
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic reset_to_idle(input string tag);
        cyc({tag, "/rst"}, 0, 0, 0, 0, F_NOP, '0);
        cyc({tag, "/idle"}, 1, 1, 0, 0, F_NOP, '0);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        exp_ret = '0;
        rst_n   = 1'b1;
        run     = 1'b0;
        mem_if.in_mem_ack = 1'b0;
        {memrd, memwrt, regwrt, branch, jump, br_taken} = '0;

        cyc("por", 0, 1, 1, 0, F_NOP, '0);
        reset_to_idle("start");

        instr("alu",     F_ALU,   0, 0, 0, 1);
        instr("load",    F_LOAD,  0, 0, 3, 1);
        instr("br_nt",   F_BR,    0, 0, 0, 1);
        instr("br_t",    F_BR,    1, 0, 0, 1);
        instr("jmp",     F_JMP,   0, 0, 0, 1);
        instr("store",   F_STORE, 0, 2, 1, 1);
        instr("nop",     F_NOP,   1, 0, 0, 1);
        instr("ldjmp",   F_LDJMP, 0, 1, 0, 1);
        instr("f_last",  F_ALU,   0, TIMEOUT - 1, 0, 1);
        instr("m_last",  F_STORE, 0, 0, TIMEOUT - 1, 1);
        for (int i = 0; i < 8; i++)
            instr("loop", F_ALU, 0, $urandom_range(0, 2), 0, 1);

        // run dropped mid-instruction: completes, then parks in IDLE
        instr("rundrop", F_ALU, 0, 0, 0, 0);
        cyc("park0", 1, 0, 0, 0, F_NOP, '0);
        cyc("park1", 1, 0, 1, 0, F_NOP, '0);
        cyc("go", 1, 1, 0, 0, F_NOP, '0);

        // reset asserted while a store waits in MEM
        cyc("rm/F", 1, 1, 1, 0, F_STORE, mk(1, 0, 0, 1, 1, 0, 0, 1, 0));
        cyc("rm/D", 1, 1, 0, 0, F_STORE, mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        cyc("rm/E", 1, 1, 0, 0, F_STORE, mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        cyc("rm/Mw", 1, 1, 0, 0, F_STORE, mk(1, 1, 1, 0, 0, 0, 0, 1, 0));
        cyc("rm/Mw", 1, 1, 0, 0, F_STORE, mk(1, 1, 1, 0, 0, 0, 0, 1, 0));
        cyc("rm/rst", 0, 1, 1, 0, F_STORE, '0);
        cyc("rm/idle", 1, 1, 0, 0, F_NOP, '0);

        // fetch never acknowledged
        for (int i = 0; i < int'(TIMEOUT); i++)
            cyc("tf/Fw", 1, 1, 0, 0, F_ALU, mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            cyc("tf/err", 1, 1, 1, 1, F_LDJMP, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));

        // store data phase never acknowledged
        reset_to_idle("tm");
        cyc("tm/F", 1, 1, 1, 0, F_STORE, mk(1, 0, 0, 1, 1, 0, 0, 1, 0));
        cyc("tm/D", 1, 1, 0, 0, F_STORE, mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        cyc("tm/E", 1, 1, 0, 0, F_STORE, mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < int'(TIMEOUT); i++)
            cyc("tm/Mw", 1, 1, 0, 0, F_STORE, mk(1, 1, 1, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            cyc("tm/err", 1, 1, 1, 0, F_STORE, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));

        reset_to_idle("end");
        instr("final", F_LOAD, 0, 0, 0, 1);
        cyc("tail", 1, 0, 0, 0, F_NOP, mk(1, 0, 0, 0, 0, 0, 0, 1, 0));

        @(negedge clk);
        #1;
        check("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
